// File: rtl/dff_pipe.sv
// Elastic pipeline register: STAGES data registers with per-stage valid bits,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe #(
  parameter int              WIDTH       = 16,
  parameter int              STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             OCC_W       = $clog2(STAGES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Handshake: an item moves across a port on a rising edge exactly when
  // valid && ready are both high in the cycle before it; valid never waits on
  // ready, and ready may depend combinationally on downstream ready.

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              in_xfer, out_xfer;

  // A stage can take new data when it is empty or its own content leaves.
  always_comb begin
    logic r;
    r = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r      = !v_q[i] || r;
      rdy[i] = r;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v_q[STAGES-1] && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = in_xfer;
      if (in_xfer) d_d[0] = in_data;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

  // Flush clears only the valid bits; data registers keep their contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < STAGES; i++) d_q[i] <= RESET_VALUE;
    end else if (flush) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: three instances (3, 4 and 1 stages) against an
// item-position model, plus directed vectors with hand-computed values.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        fl  [3];
  logic        iv  [3];
  logic        ord [3];
  logic [15:0] din [3];
  logic        ov  [3];
  logic        ir  [3];
  logic [15:0] dout[3];
  logic [1:0]  occ_a;
  logic [2:0]  occ_b;
  logic [0:0]  occ_c;

  int total = 0;
  int bad   = 0;

  int          stg[3] = '{3, 4, 1};
  logic [15:0] rvs[3] = '{16'hA5A5, 16'h0000, 16'h5A5A};

  dff_pipe #(.WIDTH(16), .STAGES(3), .RESET_VALUE(16'hA5A5)) u_a (
    .clock(clk), .reset(rst[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_ready(ord[0]), .out_data(dout[0]),
    .occupancy(occ_a));

  dff_pipe #(.WIDTH(16), .STAGES(4)) u_b (
    .clock(clk), .reset(rst[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_ready(ord[1]), .out_data(dout[1]),
    .occupancy(occ_b));

  dff_pipe #(.WIDTH(16), .STAGES(1), .RESET_VALUE(16'h5A5A)) u_c (
    .clock(clk), .reset(rst[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[2]), .out_valid(ov[2]), .out_ready(ord[2]), .out_data(dout[2]),
    .occupancy(occ_c));

  // ---------------- checkers ----------------
  task automatic chkb(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ_a);
      1:       return int'(occ_b);
      default: return int'(occ_c);
    endcase
  endfunction

  // ---------------- model: items in FIFO order with their stage positions ----------------
  int          mcnt [3];
  int          mpos [3][4];
  logic [15:0] mdat [3][4];
  logic [15:0] mlast[3];
  bit          armed[3];

  // Item 0 is the oldest. It advances unless it sits at the output unconsumed;
  // a later item advances if there is a gap ahead of it or the item ahead advances.
  function automatic logic [3:0] m_moves(input int k);
    logic [3:0] mv;
    mv = '0;
    for (int j = 0; j < mcnt[k]; j++) begin
      if (j == 0) mv[j] = (mpos[k][0] == stg[k] - 1) ? ord[k] : 1'b1;
      else        mv[j] = (mpos[k][j] + 1 < mpos[k][j-1]) || mv[j-1];
    end
    return mv;
  endfunction

  function automatic logic m_out_valid(input int k);
    return !fl[k] && (mcnt[k] > 0) && (mpos[k][0] == stg[k] - 1);
  endfunction

  function automatic logic m_in_ready(input int k);
    logic [3:0] mv;
    if (fl[k]) return 1'b0;
    if (mcnt[k] == 0) return 1'b1;
    if (mpos[k][mcnt[k]-1] != 0) return 1'b1;
    mv = m_moves(k);
    return mv[mcnt[k]-1];
  endfunction

  task automatic m_step(input int k);
    logic [3:0] mv;
    logic       rin, vout;
    int         n;
    if (rst[k]) begin
      mcnt[k]  = 0;
      mlast[k] = rvs[k];
      armed[k] = 1'b1;
    end else if (fl[k]) begin
      mcnt[k] = 0;
    end else begin
      mv   = m_moves(k);
      rin  = m_in_ready(k);
      vout = m_out_valid(k);
      for (int j = 0; j < mcnt[k]; j++) begin
        if (mv[j]) begin
          mpos[k][j]++;
          if (mpos[k][j] == stg[k] - 1) mlast[k] = mdat[k][j];
        end
      end
      if (vout && ord[k]) begin
        for (int j = 1; j < mcnt[k]; j++) begin
          mdat[k][j-1] = mdat[k][j];
          mpos[k][j-1] = mpos[k][j];
        end
        mcnt[k]--;
      end
      if (iv[k] && rin) begin
        n          = mcnt[k];
        mdat[k][n] = din[k];
        mpos[k][n] = 0;
        mcnt[k]++;
        if (stg[k] == 1) mlast[k] = din[k];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) m_step(k);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (armed[k]) begin
        chkb($sformatf("cyc_out_valid_%0d", k), ov[k], m_out_valid(k));
        chkb($sformatf("cyc_in_ready_%0d", k), ir[k], m_in_ready(k));
        chkw($sformatf("cyc_out_data_%0d", k), dout[k], mlast[k]);
        chki($sformatf("cyc_occupancy_%0d", k), occ_of(k), mcnt[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  logic [15:0] bp_vals[3] = '{16'h1111, 16'h2222, 16'h3333};
  logic [15:0] seen[$];
  int          first_c, last_c;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b0; ord[k] = 1'b0; din[k] = 16'h0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    look();
    chkb("rst_out_valid", ov[0], 1'b0);
    chkw("rst_out_data", dout[0], 16'hA5A5);
    chki("rst_occupancy", int'(occ_a), 0);
    chkb("rst_in_ready", ir[0], 1'b1);
    chkw("rst_out_data_b", dout[1], 16'h0000);
    chkw("rst_out_data_c", dout[2], 16'h5A5A);

    // latency of a single item through 3 stages
    ord[0] = 1'b1; iv[0] = 1'b1; din[0] = 16'hF42F;
    look();
    chkb("lat_in_ready", ir[0], 1'b1);
    tick(); iv[0] = 1'b0; look();
    chkb("lat_edge1_valid", ov[0], 1'b0);
    tick(); look();
    chkb("lat_edge2_valid", ov[0], 1'b0);
    tick(); look();
    chkb("lat_edge3_valid", ov[0], 1'b1);
    chkw("lat_edge3_data", dout[0], 16'hF42F);
    tick(); look();
    chkb("lat_edge4_valid", ov[0], 1'b0);

    // back-to-back stream 1..8
    first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      iv[0] = (c < 8); din[0] = 16'(c + 1);
      look();
      if (ov[0]) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        seen.push_back(dout[0]);
      end
      tick();
    end
    iv[0] = 1'b0;
    chki("stream_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      chkw($sformatf("stream_item_%0d", i), seen[i], 16'(i + 1));
    chki("stream_first_cycle", first_c, 3);
    chki("stream_span", last_c - first_c, 7);

    // backpressure fill, then release with simultaneous in/out
    ord[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; din[0] = bp_vals[i];
      look();
      chkb($sformatf("bp_accept_%0d", i), ir[0], 1'b1);
      tick();
    end
    din[0] = 16'h4444;
    look();
    chkb("bp_full_in_ready", ir[0], 1'b0);
    chki("bp_full_occupancy", int'(occ_a), 3);
    chkw("bp_full_head", dout[0], 16'h1111);
    ord[0] = 1'b1;
    look();
    chkb("bp_release_in_ready", ir[0], 1'b1);
    chkb("bp_release_out_valid", ov[0], 1'b1);
    tick(); iv[0] = 1'b0; look();
    chki("bp_swap_occupancy", int'(occ_a), 3);
    chkw("bp_drain_0", dout[0], 16'h2222);
    tick(); look();
    chkw("bp_drain_1", dout[0], 16'h3333);
    tick(); look();
    chkw("bp_drain_2", dout[0], 16'h4444);
    tick(); look();
    chkb("bp_empty_valid", ov[0], 1'b0);
    chki("bp_empty_occupancy", int'(occ_a), 0);

    // bubble compaction on the 4-stage instance
    ord[1] = 1'b0; iv[1] = 1'b1; din[1] = 16'hFFFF;
    tick(); iv[1] = 1'b0;
    tick(); tick();
    iv[1] = 1'b1; din[1] = 16'h1234;
    tick(); iv[1] = 1'b0;
    tick(); tick(); look();
    chki("cmp_occupancy", int'(occ_b), 2);
    chkb("cmp_valid", ov[1], 1'b1);
    chkw("cmp_head", dout[1], 16'hFFFF);
    ord[1] = 1'b1;
    tick(); look();
    chkb("cmp_second_valid", ov[1], 1'b1);
    chkw("cmp_second_data", dout[1], 16'h1234);
    tick(); look();
    chkb("cmp_done_valid", ov[1], 1'b0);
    chki("cmp_done_occupancy", int'(occ_b), 0);

    // flush with two items in flight
    ord[0] = 1'b0; iv[0] = 1'b1; din[0] = 16'hAAAA;
    tick(); din[0] = 16'hBBBB;
    tick(); iv[0] = 1'b0;
    tick(); look();
    chki("fl_pre_occupancy", int'(occ_a), 2);
    chkw("fl_pre_head", dout[0], 16'hAAAA);
    fl[0] = 1'b1; iv[0] = 1'b1; din[0] = 16'hCCCC; ord[0] = 1'b1;
    look();
    chkb("fl_in_ready_masked", ir[0], 1'b0);
    chkb("fl_out_valid_masked", ov[0], 1'b0);
    tick(); fl[0] = 1'b0; iv[0] = 1'b0; look();
    chkb("fl_after_valid", ov[0], 1'b0);
    chki("fl_after_occupancy", int'(occ_a), 0);
    chkw("fl_after_data", dout[0], 16'hAAAA);
    chkb("fl_after_in_ready", ir[0], 1'b1);
    iv[0] = 1'b1; din[0] = 16'hDDDD;
    tick(); iv[0] = 1'b0; look();
    chkb("fl_push_edge1", ov[0], 1'b0);
    tick(); look();
    chkb("fl_push_edge2", ov[0], 1'b0);
    tick(); look();
    chkb("fl_push_edge3", ov[0], 1'b1);
    chkw("fl_push_data", dout[0], 16'hDDDD);
    chki("fl_push_occupancy", int'(occ_a), 1);
    tick();

    // reset beats flush and handshake, 3 stages
    ord[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; din[0] = 16'(16'h0A01 + i);
      tick();
    end
    iv[0] = 1'b0; look();
    chki("rf_full_occupancy", int'(occ_a), 3);
    rst[0] = 1'b1; fl[0] = 1'b1; iv[0] = 1'b1; din[0] = 16'hBEEF; ord[0] = 1'b1;
    tick();
    rst[0] = 1'b0; fl[0] = 1'b0; iv[0] = 1'b0; ord[0] = 1'b0;
    look();
    chkb("rf_valid", ov[0], 1'b0);
    chki("rf_occupancy", int'(occ_a), 0);
    chkw("rf_data", dout[0], 16'hA5A5);
    chkb("rf_in_ready", ir[0], 1'b1);

    // single-stage instance: latency, full pass-through, reset beats flush
    ord[2] = 1'b0; iv[2] = 1'b1; din[2] = 16'h7777;
    look();
    chkb("c_accept", ir[2], 1'b1);
    tick(); din[2] = 16'h8888; look();
    chkb("c_valid", ov[2], 1'b1);
    chkw("c_data", dout[2], 16'h7777);
    chki("c_occupancy", int'(occ_c), 1);
    chkb("c_full_in_ready", ir[2], 1'b0);
    ord[2] = 1'b1;
    look();
    chkb("c_full_release_in_ready", ir[2], 1'b1);
    tick(); iv[2] = 1'b0; ord[2] = 1'b0; look();
    chkw("c_next_data", dout[2], 16'h8888);
    chki("c_next_occupancy", int'(occ_c), 1);
    rst[2] = 1'b1; fl[2] = 1'b1; iv[2] = 1'b1; din[2] = 16'hBEEF; ord[2] = 1'b1;
    tick();
    rst[2] = 1'b0; fl[2] = 1'b0; iv[2] = 1'b0; ord[2] = 1'b0;
    look();
    chkb("c_rf_valid", ov[2], 1'b0);
    chki("c_rf_occupancy", int'(occ_c), 0);
    chkw("c_rf_data", dout[2], 16'h5A5A);
    chkb("c_rf_in_ready", ir[2], 1'b1);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
